// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit_pkg
//  Description : Shared constants and fetch-state encoding for the IF stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_fetch_unit_pkg;

    localparam int          c_xlen             = 32;
    localparam logic [31:0] c_reset_pc_default = 32'h0000_0000;
    localparam logic [31:0] c_pc_step_default  = 32'd4;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_fetch = 2'd1;
    localparam logic [1:0] c_st_have  = 2'd2;
    localparam logic [1:0] c_st_kill  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit
//  Description : Instruction-fetch stage: PC register, imem req/ack handshake,
//                branch redirect and stall handling.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [c_xlen-1:0] RESET_PC = c_reset_pc_default,
    parameter logic [c_xlen-1:0] PC_STEP  = c_pc_step_default
) (
    input  logic              clk,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              dmem_stall_i,
    input  logic              branch_taken_i,
    input  logic [c_xlen-1:0] branch_target_i,
    output logic              imem_req_o,
    output logic [c_xlen-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [c_xlen-1:0] imem_rdata_i,
    output logic              start_o,
    output logic [c_xlen-1:0] pc_o,
    output logic [c_xlen-1:0] instr_o,
    output logic              if_flush_o,
    output logic              mem_stall_o
);

    logic [1:0]        r_state;
    logic [c_xlen-1:0] r_pc;
    logic [c_xlen-1:0] r_instr;
    logic [c_xlen-1:0] r_redir;
    logic              r_start;

    logic [1:0]        w_state_nxt;
    logic [c_xlen-1:0] w_pc_nxt;
    logic [c_xlen-1:0] w_instr_nxt;
    logic [c_xlen-1:0] w_redir_nxt;
    logic              w_redir;
    logic [c_xlen-1:0] w_target;

    assign w_redir  = branch_taken_i && !dmem_stall_i;
    assign w_target = branch_target_i & ~c_xlen'(3);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_redir_nxt = r_redir;
        case (r_state)
            c_st_idle: begin
                if (start_i) begin
                    w_state_nxt = c_st_fetch;
                end
            end
            c_st_fetch: begin
                if (imem_ack_i) begin
                    if (w_redir) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_instr_nxt = imem_rdata_i;
                        w_state_nxt = c_st_have;
                    end
                end else if (w_redir) begin
                    w_redir_nxt = w_target;
                    w_state_nxt = c_st_kill;
                end
            end
            c_st_kill: begin
                // The stale response still has to be absorbed before re-fetching.
                if (w_redir) begin
                    w_redir_nxt = w_target;
                end
                if (imem_ack_i) begin
                    w_pc_nxt    = w_redir ? w_target : r_redir;
                    w_state_nxt = c_st_fetch;
                end
            end
            default: begin
                if (!dmem_stall_i) begin
                    if (w_redir) begin
                        w_pc_nxt    = w_target;
                        w_state_nxt = c_st_fetch;
                    end else if (!stall_i) begin
                        w_pc_nxt    = r_pc + PC_STEP;
                        w_state_nxt = c_st_fetch;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= c_st_idle;
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_redir <= '0;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_redir <= w_redir_nxt;
            r_start <= r_start | start_i;
        end
    end

    assign imem_req_o  = (r_state == c_st_fetch) || (r_state == c_st_kill);
    assign imem_addr_o = r_pc;
    assign start_o     = r_start;
    assign pc_o        = r_pc;
    assign instr_o     = r_instr;
    // Flush is combinational from the inputs, so it must be masked while reset is held.
    assign if_flush_o  = w_redir && rst_n_i;
    assign mem_stall_o = r_start && imem_req_o;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_unit
//  Description : Randomized scoreboard bench for if_fetch_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;
    localparam logic [31:0] c_pc_step  = 32'd4;

    logic        clk = 1'b0;
    logic        rst_n_i, start_i, stall_i, dmem_stall_i, branch_taken_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o, imem_ack_i, start_o, if_flush_o, mem_stall_o;
    logic [31:0] imem_addr_o, imem_rdata_i, pc_o, instr_o;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .RESET_PC (c_reset_pc),
        .PC_STEP  (c_pc_step)
    ) u_dut (
        .clk             (clk),
        .rst_n_i         (rst_n_i),
        .start_i         (start_i),
        .stall_i         (stall_i),
        .dmem_stall_i    (dmem_stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_rdata_i    (imem_rdata_i),
        .start_o         (start_o),
        .pc_o            (pc_o),
        .instr_o         (instr_o),
        .if_flush_o      (if_flush_o),
        .mem_stall_o     (mem_stall_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // Program-order model: the next delivered PC is the latest redirect target
    // since the previous delivery, otherwise the previous PC plus one step.
    logic [31:0] exp_q[$];
    logic [31:0] last_pc;
    logic        delivered_any, started, mon_en;
    logic        prev_have, prev_hold, prev_redir, prev_req, prev_ack;
    logic [31:0] prev_addr;
    int          wait_cnt;

    int          p_stall, p_dmem, p_branch, lat_min, lat_max;
    logic        no_ack, force_br;
    int          rsp_cnt, rsp_lat;
    logic        rsp_prev_req, rsp_prev_ack;

    task automatic step();
        @(posedge clk);
        if (started && rst_n_i && branch_taken_i && !dmem_stall_i) begin
            if (exp_q.size() > 0) void'(exp_q.pop_back());
            exp_q.push_back(branch_target_i & ~32'h3);
        end
        if (rst_n_i && start_i) started = 1'b1;
        #1;
        stall_i         = ($urandom_range(99) < p_stall);
        dmem_stall_i    = ($urandom_range(99) < p_dmem);
        branch_taken_i  = started && ($urandom_range(99) < p_branch);
        branch_target_i = ($urandom_range(1) == 0) ? $urandom : 32'($urandom_range(255));
        if (force_br) begin
            branch_taken_i  = 1'b1;
            dmem_stall_i    = 1'b0;
            branch_target_i = 32'hFFFF_FFFE;
            force_br        = 1'b0;
        end
        if (imem_req_o && !no_ack) begin
            if (!rsp_prev_req || rsp_prev_ack) begin
                rsp_cnt = 0;
                rsp_lat = $urandom_range(lat_max, lat_min);
            end
            imem_ack_i = (rsp_cnt == rsp_lat);
            rsp_cnt++;
        end else begin
            imem_ack_i = 1'b0;
        end
        rsp_prev_req = imem_req_o;
        rsp_prev_ack = imem_ack_i;
        imem_rdata_i = imem_ack_i ? mem_word(imem_addr_o) : $urandom;
    endtask

    always @(negedge clk) begin
        logic        have;
        logic [31:0] e;
        if (mon_en) begin
            have = started && !mem_stall_o;
            check("if_flush", 32'(if_flush_o), 32'(branch_taken_i && !dmem_stall_i));
            if (started) begin
                check("mem_stall_vs_req", 32'(mem_stall_o), 32'(imem_req_o));
                check("addr_eq_pc", imem_addr_o, pc_o);
            end
            if (have && !prev_have) begin
                wait_cnt = 0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL deliver_unexpected: got pc %h expected none", pc_o);
                end else begin
                    e = exp_q.pop_front();
                    check("deliver_pc", pc_o, e);
                    check("deliver_instr", instr_o, mem_word(e));
                    last_pc       = e;
                    delivered_any = 1'b1;
                    exp_q.push_back(e + c_pc_step);
                end
            end else if (started && !have) begin
                wait_cnt++;
                if (wait_cnt > 100) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL fetch_timeout: got %0d waiting cycles expected <= 100", wait_cnt);
                    wait_cnt = 0;
                end
            end
            if (have && delivered_any) begin
                check("have_pc", pc_o, last_pc);
                check("have_instr", instr_o, mem_word(last_pc));
            end
            if (started && !have && delivered_any)
                check("instr_hold", instr_o, mem_word(last_pc));
            if (prev_have)
                check("have_hold", 32'(have), 32'(prev_hold && !prev_redir));
            if (prev_req && !prev_ack) begin
                check("req_stable", 32'(imem_req_o), 32'd1);
                check("addr_stable", imem_addr_o, prev_addr);
            end
            prev_have  = have;
            prev_hold  = stall_i || dmem_stall_i;
            prev_redir = branch_taken_i && !dmem_stall_i;
            prev_req   = imem_req_o;
            prev_ack   = imem_ack_i;
            prev_addr  = imem_addr_o;
        end
    end

    task automatic reset_model();
        started       = 1'b0;
        delivered_any = 1'b0;
        exp_q.delete();
        exp_q.push_back(c_reset_pc);
        last_pc      = c_reset_pc;
        prev_have    = 1'b0;
        prev_hold    = 1'b0;
        prev_redir   = 1'b0;
        prev_req     = 1'b0;
        prev_ack     = 1'b0;
        prev_addr    = '0;
        wait_cnt     = 0;
        rsp_prev_req = 1'b0;
        rsp_prev_ack = 1'b0;
        rsp_cnt      = 0;
        rsp_lat      = 0;
    endtask

    task automatic set_knobs(input int ps, input int pd, input int pb, input int lmin, input int lmax);
        p_stall  = ps;
        p_dmem   = pd;
        p_branch = pb;
        lat_min  = lmin;
        lat_max  = lmax;
    endtask

    initial begin
        rst_n_i = 1'b0; start_i = 1'b0; stall_i = 1'b0; dmem_stall_i = 1'b0;
        branch_taken_i = 1'b0; branch_target_i = '0; imem_ack_i = 1'b0; imem_rdata_i = '0;
        mon_en = 1'b0; no_ack = 1'b0; force_br = 1'b0;
        set_knobs(0, 0, 0, 1, 1);
        reset_model();

        repeat (3) @(posedge clk);
        #1;
        check("rst_start_o", 32'(start_o), 32'd0);
        check("rst_pc", pc_o, c_reset_pc);
        check("rst_instr", instr_o, 32'd0);
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_mem_stall", 32'(mem_stall_o), 32'd0);
        check("rst_flush", 32'(if_flush_o), 32'd0);

        @(negedge clk); #1;
        rst_n_i = 1'b1;
        mon_en  = 1'b1;
        start_i = 1'b1;

        // Sequential fetch with a one-cycle memory.
        repeat (24) step();
        // Fully random traffic.
        set_knobs(25, 20, 10, 0, 3);
        repeat (800) step();
        // Redirect to the top word, then let the PC wrap through zero.
        set_knobs(0, 0, 0, 0, 2);
        force_br = 1'b1;
        repeat (24) step();

        // Assert reset while a request is outstanding.
        no_ack = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (imem_req_o) break;
        end
        check("pre_reset_req", 32'(imem_req_o), 32'd1);
        branch_taken_i = 1'b1;
        #2;
        mon_en  = 1'b0;
        rst_n_i = 1'b0;
        #1;
        check("midrst_req", 32'(imem_req_o), 32'd0);
        check("midrst_mem_stall", 32'(mem_stall_o), 32'd0);
        check("midrst_flush", 32'(if_flush_o), 32'd0);
        check("midrst_start_o", 32'(start_o), 32'd0);
        check("midrst_pc", pc_o, c_reset_pc);
        check("midrst_instr", instr_o, 32'd0);
        @(negedge clk); #1;
        rst_n_i = 1'b1; start_i = 1'b0; branch_taken_i = 1'b0;
        @(posedge clk); #1;
        imem_ack_i   = 1'b1;
        imem_rdata_i = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        imem_ack_i = 1'b0;
        check("late_ack_req", 32'(imem_req_o), 32'd0);
        check("late_ack_start_o", 32'(start_o), 32'd0);
        check("late_ack_pc", pc_o, c_reset_pc);
        check("late_ack_instr", instr_o, 32'd0);

        // Restart and run random traffic again from the reset PC.
        no_ack = 1'b0;
        reset_model();
        @(negedge clk); #1;
        mon_en  = 1'b1;
        start_i = 1'b1;
        set_knobs(20, 15, 8, 0, 2);
        repeat (200) step();

        @(negedge clk); #1;
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
